// File: rtl/punc_control_fsm_if.sv
// Control bundle between the PUnC controller and PUnCDatapath.
// The controller (master) reads ir and drives every datapath control input.
// ir_const carries the 11-bit constant field (ir[10:0]) to the datapath sign-extenders.
interface punc_control_fsm_if;
  logic [15:0] ir;
  logic        mem_wr_en;
  logic [2:0]  mem_r_addr_sel;
  logic        state2_STI;
  logic        STR;
  logic [2:0]  RF_wr_addr;
  logic        RF_wr_en;
  logic [2:0]  RF_r_addr_0;
  logic [2:0]  RF_r_addr_1;
  logic [1:0]  RF_w_data_sel;
  logic        ir_ld;
  logic        JMP_RET_JSRR;
  logic        pc_ld;
  logic        pc_clr;
  logic        pc_up;
  logic        add_const;
  logic [1:0]  alu_sel;
  logic        cc_en;
  logic [2:0]  nzp;
  logic [10:0] ir_const;
  logic [3:0]  SEXT_Select;
  logic        halted;

  modport master (
    input  ir,
    output mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
           RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR, pc_ld,
           pc_clr, pc_up, add_const, alu_sel, cc_en, nzp, ir_const, SEXT_Select, halted
  );

  modport slave (
    output ir,
    input  mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
           RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR, pc_ld,
           pc_clr, pc_up, add_const, alu_sel, cc_en, nzp, ir_const, SEXT_Select, halted
  );
endinterface

// File: rtl/punc_control_fsm.sv
// Multi-cycle LC3 controller for PUnCDatapath: INIT -> FETCH -> DECODE -> EXEC (-> EXEC2) -> FETCH.
// Outputs are combinational from state and ir; rst forces every output low in its cycle.
// Optional single-step mode: define PUNC_CTRL_STEP_EN to add the step input.
module punc_control_fsm #(
  parameter int unsigned FETCH_WAIT = 0
) (
  input logic clk,
  input logic rst,
`ifdef PUNC_CTRL_STEP_EN
  input logic step,
`endif
  punc_control_fsm_if.master bus
);

  typedef enum logic [2:0] {StInit, StFetch, StDecode, StExec, StExec2, StHalt} state_e;

  localparam logic [3:0] WaitLast = 4'(FETCH_WAIT);

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpJsr = 4'b0100;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpRti = 4'b1000;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpRsv = 4'b1101;
  localparam logic [3:0] OpLea = 4'b1110;
  localparam logic [3:0] OpTrap = 4'b1111;

  localparam logic [1:0] AluPass = 2'd0;
  localparam logic [1:0] AluAdd  = 2'd1;
  localparam logic [1:0] AluAnd  = 2'd2;
  localparam logic [1:0] AluNot  = 2'd3;

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       fetch_go;
  logic [3:0] opcode;
  logic [2:0] dr, sr1, sr2;

  assign opcode = bus.ir[15:12];
  assign dr     = bus.ir[11:9];
  assign sr1    = bus.ir[8:6];
  assign sr2    = bus.ir[2:0];

  // Final FETCH cycle: wait margin exhausted (and, in step mode, a step pulse present).
`ifdef PUNC_CTRL_STEP_EN
  assign fetch_go = (wait_q == WaitLast) && step;
`else
  assign fetch_go = (wait_q == WaitLast);
`endif

  // State and fetch-wait counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    wait_d  = 4'd0;
    unique case (state_q)
      StInit: state_d = StFetch;
      StFetch: begin
        if (fetch_go) begin
          state_d = StDecode;
        end else begin
          // Saturate at the last wait cycle so step mode can hold there.
          wait_d = (wait_q == WaitLast) ? wait_q : wait_q + 4'd1;
        end
      end
      StDecode: begin
        if (opcode == OpTrap) begin
          state_d = StHalt;
        end else if (opcode == OpRti || opcode == OpRsv) begin
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec:  state_d = (opcode == OpLdi || opcode == OpSti) ? StExec2 : StFetch;
      StExec2: state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StInit;
    endcase
  end

  // Control outputs decoded from state and ir.
  always_comb begin
    bus.mem_wr_en      = 1'b0;
    bus.mem_r_addr_sel = 3'd0;
    bus.state2_STI     = 1'b0;
    bus.STR            = 1'b0;
    bus.RF_wr_addr     = 3'd0;
    bus.RF_wr_en       = 1'b0;
    bus.RF_r_addr_0    = 3'd0;
    bus.RF_r_addr_1    = 3'd0;
    bus.RF_w_data_sel  = 2'd0;
    bus.ir_ld          = 1'b0;
    bus.JMP_RET_JSRR   = 1'b0;
    bus.pc_ld          = 1'b0;
    bus.pc_clr         = 1'b0;
    bus.pc_up          = 1'b0;
    bus.add_const      = 1'b0;
    bus.alu_sel        = AluPass;
    bus.cc_en          = 1'b0;
    bus.nzp            = 3'd0;
    bus.ir_const       = bus.ir[10:0];
    bus.SEXT_Select    = 4'b0000;
    bus.halted         = 1'b0;

    unique case (state_q)
      StInit: bus.pc_clr = 1'b1;
      StFetch: begin
        bus.mem_r_addr_sel = 3'd0;
        bus.ir_ld          = fetch_go;
        bus.pc_up          = fetch_go;
      end
      StDecode: ;
      StExec: begin
        case (opcode)
          OpAdd, OpAnd: begin
            bus.RF_r_addr_0   = sr1;
            bus.RF_r_addr_1   = sr2;
            bus.add_const     = bus.ir[5];
            bus.alu_sel       = (opcode == OpAdd) ? AluAdd : AluAnd;
            bus.SEXT_Select   = 4'b1000;
            bus.RF_wr_addr    = dr;
            bus.RF_wr_en      = 1'b1;
            bus.RF_w_data_sel = 2'd0;
            bus.cc_en         = 1'b1;
          end
          OpNot: begin
            bus.alu_sel     = AluNot;
            bus.RF_r_addr_0 = sr1;
            bus.RF_wr_addr  = dr;
            bus.RF_wr_en    = 1'b1;
            bus.cc_en       = 1'b1;
          end
          OpBr: begin
            bus.nzp         = bus.ir[11:9];
            bus.SEXT_Select = 4'b0010;
          end
          OpJmp: begin
            bus.pc_ld        = 1'b1;
            bus.JMP_RET_JSRR = 1'b1;
            bus.alu_sel      = AluPass;
            bus.RF_r_addr_0  = sr1;
          end
          OpJsr: begin
            bus.RF_wr_addr    = 3'd7;
            bus.RF_wr_en      = 1'b1;
            bus.RF_w_data_sel = 2'd1;
            bus.pc_ld         = 1'b1;
            if (bus.ir[11]) begin
              bus.SEXT_Select = 4'b0001;
            end else begin
              // Base register is read this cycle, so JSRR R7 jumps to the old R7.
              bus.JMP_RET_JSRR = 1'b1;
              bus.alu_sel      = AluPass;
              bus.RF_r_addr_0  = sr1;
            end
          end
          OpLd: begin
            bus.mem_r_addr_sel = 3'd1;
            bus.SEXT_Select    = 4'b0010;
            bus.RF_wr_addr     = dr;
            bus.RF_wr_en       = 1'b1;
            bus.RF_w_data_sel  = 2'd2;
            bus.cc_en          = 1'b1;
          end
          OpLea: begin
            bus.RF_wr_addr    = dr;
            bus.RF_wr_en      = 1'b1;
            bus.RF_w_data_sel = 2'd3;
            bus.SEXT_Select   = 4'b0010;
          end
          OpLdr: begin
            bus.mem_r_addr_sel = 3'd4;
            bus.alu_sel        = AluAdd;
            bus.add_const      = 1'b1;
            bus.SEXT_Select    = 4'b0100;
            bus.RF_r_addr_0    = sr1;
            bus.RF_wr_addr     = dr;
            bus.RF_wr_en       = 1'b1;
            bus.RF_w_data_sel  = 2'd2;
            bus.cc_en          = 1'b1;
          end
          OpSt: begin
            bus.mem_wr_en   = 1'b1;
            bus.alu_sel     = AluPass;
            bus.RF_r_addr_0 = dr;
            bus.SEXT_Select = 4'b0010;
          end
          OpStr: begin
            bus.mem_wr_en   = 1'b1;
            bus.STR         = 1'b1;
            bus.alu_sel     = AluAdd;
            bus.add_const   = 1'b1;
            bus.SEXT_Select = 4'b0100;
            bus.RF_r_addr_0 = sr1;
            bus.RF_r_addr_1 = dr;
          end
          OpLdi, OpSti: begin
            // Datapath latches the pointer word into its indirect register.
            bus.mem_r_addr_sel = 3'd1;
            bus.SEXT_Select    = 4'b0010;
          end
          default: ;
        endcase
      end
      StExec2: begin
        if (opcode == OpLdi) begin
          bus.mem_r_addr_sel = 3'd2;
          bus.RF_wr_addr     = dr;
          bus.RF_wr_en       = 1'b1;
          bus.RF_w_data_sel  = 2'd2;
          bus.cc_en          = 1'b1;
        end else begin
          bus.mem_wr_en   = 1'b1;
          bus.state2_STI  = 1'b1;
          bus.STR         = 1'b1;
          bus.RF_r_addr_1 = dr;
        end
      end
      StHalt: begin
        bus.ir_const = 11'd0;
        bus.halted   = 1'b1;
      end
      default: ;
    endcase

    // Reset wins in the same cycle so no write escapes a mid-instruction reset.
    if (rst) begin
      bus.mem_wr_en      = 1'b0;
      bus.mem_r_addr_sel = 3'd0;
      bus.state2_STI     = 1'b0;
      bus.STR            = 1'b0;
      bus.RF_wr_addr     = 3'd0;
      bus.RF_wr_en       = 1'b0;
      bus.RF_r_addr_0    = 3'd0;
      bus.RF_r_addr_1    = 3'd0;
      bus.RF_w_data_sel  = 2'd0;
      bus.ir_ld          = 1'b0;
      bus.JMP_RET_JSRR   = 1'b0;
      bus.pc_ld          = 1'b0;
      bus.pc_clr         = 1'b0;
      bus.pc_up          = 1'b0;
      bus.add_const      = 1'b0;
      bus.alu_sel        = AluPass;
      bus.cc_en          = 1'b0;
      bus.nzp            = 3'd0;
      bus.ir_const       = 11'd0;
      bus.SEXT_Select    = 4'b0000;
      bus.halted         = 1'b0;
    end
  end

endmodule
